up_down_counter_mod: RTL and testbench

// - Parametrised up/down counter; next generation of the fixed 4-bit up/down counter.
// - Adds the following:
//   - Configurable width.
//   - Runtime modulus (count range 0..modulus).
//   - Wrap or saturate mode.
//   - Count enable and synchronous parallel load.
//   - Registered overflow/underflow pulses.
// - Used as a general event/timer counter; ovf/unf allow cascading.

---
 rtl/up_down_counter_pkg.sv | 7 +
 rtl/up_down_next_val.sv | 41 ++++
 rtl/up_down_counter_mod.sv | 60 ++++++
 tb/tb_up_down_counter_mod.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared encodings for the up/down counter: direction and limit-mode codes.
package up_down_counter_pkg;
   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/up_down_next_val.sv
// Combinational step calculator: next count plus overflow/underflow flags for one
// enabled step against a runtime modulus.
module up_down_next_val
   import up_down_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] counter,
   input  logic [WIDTH-1:0] modulus,
   input  logic             up_down,
   input  logic             sat,
   output logic [WIDTH-1:0] next,
   output logic             ovf,
   output logic             unf
);

   always_comb begin
      next = counter;
      ovf  = 1'b0;
      unf  = 1'b0;
      if (up_down == DIR_UP) begin
         if (counter < modulus) begin
            next = counter + WIDTH'(1);
         end else begin
            // also catches a count stranded above a freshly lowered modulus
            ovf  = 1'b1;
            next = (sat == MODE_WRAP) ? '0 : modulus;
         end
      end else if (up_down == DIR_DOWN) begin
         if (counter > modulus) begin
            next = modulus;
         end else if (counter != '0) begin
            next = counter - WIDTH'(1);
         end else begin
            unf  = 1'b1;
            next = (sat == MODE_SAT) ? '0 : modulus;
         end
      end
   end

endmodule

// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter with runtime modulus, wrap/saturate mode,
// synchronous load and registered one-cycle ovf/unf pulses.
module up_down_counter_mod
   import up_down_counter_pkg::*;
#(
   parameter int              WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_down,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] counter,
   output logic             ovf,
   output logic             unf,
   output logic             at_max,
   output logic             at_zero
);

   logic [WIDTH-1:0] step_val;
   logic             step_ovf;
   logic             step_unf;

   up_down_next_val #(.WIDTH(WIDTH)) u_next (
      .counter (counter),
      .modulus (modulus),
      .up_down (up_down),
      .sat     (sat),
      .next    (step_val),
      .ovf     (step_ovf),
      .unf     (step_unf)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter <= RESET_VAL;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else if (load) begin
         counter <= (load_val > modulus) ? modulus : load_val;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else if (en) begin
         counter <= step_val;
         ovf     <= step_ovf;
         unf     <= step_unf;
      end else begin
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end
   end

   assign at_max  = (counter == modulus);
   assign at_zero = (counter == '0);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod at WIDTH=4: reset, wrap sequence and a
// table of hand-computed step/load/hold vectors.
module tb_up_down_counter_mod;
   import up_down_counter_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         en, up_down, sat, load;
   logic [W-1:0] load_val, modulus;
   logic [W-1:0] counter;
   logic         ovf, unf, at_max, at_zero;

   int n_vec = 0;
   int n_err = 0;

   up_down_counter_mod #(.WIDTH(W), .RESET_VAL('0)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_down  (up_down),
      .sat      (sat),
      .load     (load),
      .load_val (load_val),
      .modulus  (modulus),
      .counter  (counter),
      .ovf      (ovf),
      .unf      (unf),
      .at_max   (at_max),
      .at_zero  (at_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         load;
      logic [W-1:0] load_val;
      logic         en;
      logic         up_down;
      logic         sat;
      logic [W-1:0] modulus;
      logic [W-1:0] exp_cnt;
      logic         exp_ovf;
      logic         exp_unf;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t mk(logic ld, logic [W-1:0] lv, logic e, logic ud, logic s,
                               logic [W-1:0] m, logic [W-1:0] c, logic o, logic u);
      vec_t v;
      v.load = ld; v.load_val = lv; v.en = e; v.up_down = ud; v.sat = s;
      v.modulus = m; v.exp_cnt = c; v.exp_ovf = o; v.exp_unf = u;
      return v;
   endfunction

   task automatic check(string name, logic [W-1:0] c, logic o, logic u, logic am, logic az);
      n_vec++;
      if (counter !== c || ovf !== o || unf !== u || at_max !== am || at_zero !== az) begin
         n_err++;
         $display("FAIL %s: got cnt=%0d ovf=%b unf=%b at_max=%b at_zero=%b, want cnt=%0d ovf=%b unf=%b at_max=%b at_zero=%b",
                  name, counter, ovf, unf, at_max, at_zero, c, o, u, am, az);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] exp_c;

      // load 2, down x4 under saturate
      tbl[0]  = mk(1, 2,  0, DIR_DOWN, MODE_SAT,  15, 2, 0, 0);
      tbl[1]  = mk(0, 0,  1, DIR_DOWN, MODE_SAT,  15, 1, 0, 0);
      tbl[2]  = mk(0, 0,  1, DIR_DOWN, MODE_SAT,  15, 0, 0, 0);
      tbl[3]  = mk(0, 0,  1, DIR_DOWN, MODE_SAT,  15, 0, 0, 1);
      tbl[4]  = mk(0, 0,  1, DIR_DOWN, MODE_SAT,  15, 0, 0, 1);
      // load clamp beats en, then wrap
      tbl[5]  = mk(1, 12, 1, DIR_UP,   MODE_WRAP, 5,  5, 0, 0);
      tbl[6]  = mk(0, 0,  1, DIR_UP,   MODE_WRAP, 5,  0, 1, 0);
      // modulus lowered under a count of 12
      tbl[7]  = mk(1, 12, 0, DIR_UP,   MODE_WRAP, 15, 12, 0, 0);
      tbl[8]  = mk(0, 0,  1, DIR_UP,   MODE_WRAP, 8,  0, 1, 0);
      tbl[9]  = mk(1, 12, 0, DIR_UP,   MODE_WRAP, 15, 12, 0, 0);
      tbl[10] = mk(0, 0,  1, DIR_DOWN, MODE_WRAP, 8,  8, 0, 0);
      // hold x5
      for (int i = 11; i < 16; i++) tbl[i] = mk(0, 0, 0, DIR_UP, MODE_WRAP, 8, 8, 0, 0);
      // modulus 0
      tbl[16] = mk(0, 0,  1, DIR_UP,   MODE_WRAP, 0,  0, 1, 0);
      tbl[17] = mk(0, 0,  1, DIR_UP,   MODE_WRAP, 0,  0, 1, 0);
      tbl[18] = mk(0, 0,  1, DIR_UP,   MODE_WRAP, 0,  0, 1, 0);
      tbl[19] = mk(0, 0,  1, DIR_DOWN, MODE_WRAP, 0,  0, 0, 1);
      // saturate up, hold, down wrap at zero
      tbl[20] = mk(1, 4,  0, DIR_UP,   MODE_SAT,  5,  4, 0, 0);
      tbl[21] = mk(0, 0,  1, DIR_UP,   MODE_SAT,  5,  5, 0, 0);
      tbl[22] = mk(0, 0,  1, DIR_UP,   MODE_SAT,  5,  5, 1, 0);
      tbl[23] = mk(0, 0,  0, DIR_UP,   MODE_SAT,  5,  5, 0, 0);
      tbl[24] = mk(0, 0,  1, DIR_DOWN, MODE_WRAP, 5,  4, 0, 0);
      tbl[25] = mk(1, 0,  0, DIR_DOWN, MODE_WRAP, 5,  0, 0, 0);
      tbl[26] = mk(0, 0,  1, DIR_DOWN, MODE_WRAP, 5,  5, 0, 1);

      reset = 1'b1; en = 0; up_down = DIR_UP; sat = MODE_WRAP; load = 0;
      load_val = '0; modulus = 4'd9;
      #12;
      check("reset_state", 0, 0, 0, 0, 1);
      reset = 1'b0;

      // count to 7 then hit reset between clock edges
      @(negedge clk);
      en = 1;
      for (int i = 1; i <= 7; i++) step();
      check("pre_reset_7", 7, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1 check("async_reset", 0, 0, 0, 0, 1);
      en = 0;
      @(negedge clk);
      reset = 1'b0;
      en = 1;

      // wrap mode, modulus 9, three full periods
      for (int i = 0; i < 30; i++) begin
         step();
         exp_c = W'((i + 1) % 10);
         check("up_wrap", exp_c, exp_c == 0, 0, exp_c == 9, exp_c == 0);
      end

      for (int i = 0; i < 27; i++) begin
         load = tbl[i].load; load_val = tbl[i].load_val; en = tbl[i].en;
         up_down = tbl[i].up_down; sat = tbl[i].sat; modulus = tbl[i].modulus;
         step();
         check($sformatf("vec%0d", i), tbl[i].exp_cnt, tbl[i].exp_ovf, tbl[i].exp_unf,
               tbl[i].exp_cnt == tbl[i].modulus, tbl[i].exp_cnt == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish before 100000");
      $fatal(1);
   end

endmodule
